// File: rtl/pc_redirect_unit.sv
// Fetch program counter with branch/JAL/JALR redirect, a pending-redirect hold
// while instruction memory is not ready, and IF/ID, ID/EX flush generation.
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  decision_in,
   input  logic [31:0] branch_target,
   input  logic [31:0] jal_target,
   input  logic [31:0] jalr_target,
   input  logic        stall,
   input  logic        imem_ready,
   output logic [31:0] pc_out,
   output logic [31:0] npc_out,
   output logic        imem_req,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        redirect_pending,
   output logic [15:0] redirect_count,
   output logic        decode_err
);

   typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] pend_target_r;
   logic [15:0] count_r;
   logic        decode_err_r;

   logic        redirect_s;
   logic        reserved_s;
   logic [31:0] target_s;

   // Decode the redirect select into a halfword-aligned target and a reserved-code flag.
   always_comb begin
      redirect_s = 1'b0;
      reserved_s = 1'b0;
      target_s   = 32'h0000_0000;
      case (decision_in)
         3'b000: redirect_s = 1'b0;
         3'b001: begin
            redirect_s = 1'b1;
            target_s   = branch_target & 32'hFFFF_FFFE;
         end
         3'b010: begin
            redirect_s = 1'b1;
            target_s   = jal_target & 32'hFFFF_FFFE;
         end
         3'b011: begin
            redirect_s = 1'b1;
            target_s   = jalr_target & 32'hFFFF_FFFE;
         end
         3'b100, 3'b101, 3'b110, 3'b111: reserved_s = 1'b1;
         default: redirect_s = 1'b0;
      endcase
   end

   // Flush requests; while a redirect is pending every fetched word is wrong-path.
   always_comb begin
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (reset) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (state_r == PEND) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b0;
      end else if (redirect_s) begin
         if_id_flush = 1'b1;
         id_ex_flush = (decision_in == 3'b001);
      end else begin
         if_id_flush = 1'b0;
         id_ex_flush = 1'b0;
      end
   end

   // PC sequencing, pending-redirect state, redirect counter and sticky decode error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= RUN;
         pc_r          <= RESET_PC;
         pend_target_r <= 32'h0000_0000;
         count_r       <= 16'h0000;
         decode_err_r  <= 1'b0;
      end else begin
         decode_err_r <= decode_err_r | reserved_s;
         case (state_r)
            RUN: begin
               if (redirect_s) begin
                  if (count_r != 16'hFFFF) begin
                     count_r <= count_r + 16'h0001;
                  end
                  if (imem_ready) begin
                     pc_r <= target_s;
                  end else begin
                     pend_target_r <= target_s;
                     state_r       <= PEND;
                  end
               end else if (!stall && imem_ready) begin
                  pc_r <= pc_r + 32'h0000_0004;
               end
            end
            PEND: begin
               // Stall is ignored here: the held instruction is wrong-path anyway.
               if (imem_ready) begin
                  pc_r          <= pend_target_r;
                  pend_target_r <= 32'h0000_0000;
                  state_r       <= RUN;
               end
            end
            default: state_r <= RUN;
         endcase
      end
   end

   assign pc_out           = pc_r;
   assign npc_out          = pc_r + 32'h0000_0004;
   assign imem_req         = ~reset;
   assign redirect_pending = (state_r == PEND) & ~reset;
   assign redirect_count   = count_r;
   assign decode_err       = decode_err_r;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch PC.
module tb_pc_redirect_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  decision_in;
   logic [31:0] branch_target;
   logic [31:0] jal_target;
   logic [31:0] jalr_target;
   logic        stall;
   logic        imem_ready;
   logic [31:0] pc_out;
   logic [31:0] npc_out;
   logic        imem_req;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        redirect_pending;
   logic [15:0] redirect_count;
   logic        decode_err;

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural model state
   logic [31:0] m_pc;
   bit          m_pending;
   logic [31:0] m_ptarget;
   int          m_count;
   bit          m_err;

   pc_redirect_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .decision_in(decision_in),
      .branch_target(branch_target), .jal_target(jal_target), .jalr_target(jalr_target),
      .stall(stall), .imem_ready(imem_ready), .pc_out(pc_out), .npc_out(npc_out),
      .imem_req(imem_req), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .redirect_pending(redirect_pending), .redirect_count(redirect_count),
      .decode_err(decode_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [2:0] dec, input logic [31:0] bt, input logic [31:0] jt,
                         input logic [31:0] jrt, input logic st, input logic rdy);
      decision_in   = dec;
      branch_target = bt;
      jal_target    = jt;
      jalr_target   = jrt;
      stall         = st;
      imem_ready    = rdy;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      reset = 1'b0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_update;
      logic [31:0] tgt;
      if (reset) begin
         m_pc = RST_PC; m_pending = 0; m_ptarget = 32'h0; m_count = 0; m_err = 0;
      end else begin
         if (decision_in >= 3'd4) m_err = 1;
         if (m_pending) begin
            if (imem_ready) begin
               m_pc = m_ptarget;
               m_pending = 0;
            end
         end else if (decision_in >= 3'd1 && decision_in <= 3'd3) begin
            tgt = (decision_in == 3'd1) ? branch_target :
                  (decision_in == 3'd2) ? jal_target : jalr_target;
            tgt = {tgt[31:1], 1'b0};
            m_count = (m_count >= 65535) ? 65535 : m_count + 1;
            if (imem_ready) m_pc = tgt;
            else begin
               m_ptarget = tgt;
               m_pending = 1;
            end
         end else if (!stall && imem_ready) begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      set_in(3'd1, 32'h40, 32'h0, 32'h0, 1'b0, 1'b1);
      #1;
      n_checks++; if (if_id_flush !== 1'b1) $display("FAIL rst_if_id_flush: got %b exp 1", if_id_flush); else n_pass++;
      n_checks++; if (id_ex_flush !== 1'b1) $display("FAIL rst_id_ex_flush: got %b exp 1", id_ex_flush); else n_pass++;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_imem_req: got %b exp 0", imem_req); else n_pass++;
      n_checks++; if (redirect_pending !== 1'b0) $display("FAIL rst_pending: got %b exp 0", redirect_pending); else n_pass++;
      tick();
      n_checks++; if (pc_out !== RST_PC) $display("FAIL rst_pc: got %h exp %h", pc_out, RST_PC); else n_pass++;
      n_checks++; if (redirect_count !== 16'h0) $display("FAIL rst_count: got %h exp 0", redirect_count); else n_pass++;
      n_checks++; if (decode_err !== 1'b0) $display("FAIL rst_decode_err: got %b exp 0", decode_err); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_sequential;
      do_reset();
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++; if (pc_out !== 32'(4 * k)) $display("FAIL seq_pc%0d: got %h exp %h", k, pc_out, 32'(4 * k)); else n_pass++;
         n_checks++; if (imem_req !== 1'b1) $display("FAIL seq_imem_req%0d: got %b exp 1", k, imem_req); else n_pass++;
         n_checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) $display("FAIL seq_flush%0d: got %b%b exp 00", k, if_id_flush, id_ex_flush); else n_pass++;
         if (k < 3) tick();
      end
   endtask

   task automatic test_branch_stall;
      do_reset();
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      repeat (64) tick();
      n_checks++; if (pc_out !== 32'h100) $display("FAIL br_pre_pc: got %h exp 00000100", pc_out); else n_pass++;
      set_in(3'd1, 32'h200, 32'h0, 32'h0, 1'b1, 1'b1);
      #1;
      n_checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) $display("FAIL br_flush: got %b%b exp 11", if_id_flush, id_ex_flush); else n_pass++;
      tick();
      n_checks++; if (pc_out !== 32'h200) $display("FAIL br_pc: got %h exp 00000200", pc_out); else n_pass++;
      n_checks++; if (redirect_count !== 16'd1) $display("FAIL br_count: got %0d exp 1", redirect_count); else n_pass++;
   endtask

   task automatic test_jalr_pend;
      set_in(3'd3, 32'h0, 32'h0, 32'h305, 1'b0, 1'b0);
      #1;
      n_checks++; if ({if_id_flush, id_ex_flush} !== 2'b10) $display("FAIL jalr_flush: got %b%b exp 10", if_id_flush, id_ex_flush); else n_pass++;
      n_checks++; if (redirect_pending !== 1'b0) $display("FAIL jalr_pend0: got %b exp 0", redirect_pending); else n_pass++;
      tick();
      n_checks++; if (redirect_pending !== 1'b1) $display("FAIL jalr_pend1: got %b exp 1", redirect_pending); else n_pass++;
      n_checks++; if (pc_out !== 32'h200) $display("FAIL jalr_pc_hold1: got %h exp 00000200", pc_out); else n_pass++;
      set_in(3'd1, 32'h800, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      n_checks++; if ({if_id_flush, id_ex_flush} !== 2'b10) $display("FAIL pend_flush: got %b%b exp 10", if_id_flush, id_ex_flush); else n_pass++;
      tick();
      n_checks++; if (redirect_pending !== 1'b1) $display("FAIL jalr_pend2: got %b exp 1", redirect_pending); else n_pass++;
      n_checks++; if (pc_out !== 32'h200) $display("FAIL jalr_pc_hold2: got %h exp 00000200", pc_out); else n_pass++;
      set_in(3'd1, 32'h800, 32'h0, 32'h0, 1'b1, 1'b1);
      tick();
      n_checks++; if (pc_out !== 32'h304) $display("FAIL jalr_pc: got %h exp 00000304", pc_out); else n_pass++;
      n_checks++; if (redirect_pending !== 1'b0) $display("FAIL jalr_pend_clr: got %b exp 0", redirect_pending); else n_pass++;
      n_checks++; if (redirect_count !== 16'd2) $display("FAIL jalr_count: got %0d exp 2", redirect_count); else n_pass++;
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      n_checks++; if (pc_out !== 32'h308) $display("FAIL jalr_after_seq: got %h exp 00000308", pc_out); else n_pass++;
   endtask

   task automatic test_wrap;
      set_in(3'd2, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
      tick();
      n_checks++; if (pc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_jal_pc: got %h exp fffffffc", pc_out); else n_pass++;
      n_checks++; if (npc_out !== 32'h0) $display("FAIL wrap_npc: got %h exp 00000000", npc_out); else n_pass++;
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      n_checks++; if (pc_out !== 32'h0) $display("FAIL wrap_pc: got %h exp 00000000", pc_out); else n_pass++;
   endtask

   task automatic test_decode_err;
      do_reset();
      set_in(3'd5, 32'h700, 32'h700, 32'h700, 1'b0, 1'b1);
      #1;
      n_checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) $display("FAIL rsv_flush: got %b%b exp 00", if_id_flush, id_ex_flush); else n_pass++;
      tick();
      n_checks++; if (pc_out !== 32'h4) $display("FAIL rsv_pc: got %h exp 00000004", pc_out); else n_pass++;
      n_checks++; if (decode_err !== 1'b1) $display("FAIL rsv_err_set: got %b exp 1", decode_err); else n_pass++;
      n_checks++; if (redirect_count !== 16'd0) $display("FAIL rsv_count: got %0d exp 0", redirect_count); else n_pass++;
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      repeat (3) tick();
      n_checks++; if (decode_err !== 1'b1) $display("FAIL rsv_err_sticky: got %b exp 1", decode_err); else n_pass++;
      set_in(3'd1, 32'h500, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      n_checks++; if (redirect_pending !== 1'b1) $display("FAIL rstpend_pend: got %b exp 1", redirect_pending); else n_pass++;
      reset = 1'b1;
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      #1;
      n_checks++; if (redirect_pending !== 1'b0) $display("FAIL rstpend_pend_out: got %b exp 0", redirect_pending); else n_pass++;
      tick();
      reset = 1'b0;
      n_checks++; if (pc_out !== RST_PC) $display("FAIL rstpend_pc: got %h exp %h", pc_out, RST_PC); else n_pass++;
      n_checks++; if (decode_err !== 1'b0) $display("FAIL rstpend_err: got %b exp 0", decode_err); else n_pass++;
      tick();
      n_checks++; if (pc_out !== 32'h4) $display("FAIL rstpend_discard: got %h exp 00000004", pc_out); else n_pass++;
   endtask

   task automatic test_random;
      bit exp_if;
      bit exp_id;
      reset = 1'b1;
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      model_update();
      tick();
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 9) == 0) decision_in = 3'($urandom_range(4, 7));
         else decision_in = 3'($urandom_range(0, 3));
         branch_target = $urandom;
         jal_target    = $urandom;
         jalr_target   = $urandom;
         stall         = 1'($urandom_range(0, 1));
         imem_ready    = ($urandom_range(0, 3) != 0);
         #1;
         exp_if = reset || m_pending || (decision_in >= 3'd1 && decision_in <= 3'd3);
         exp_id = reset || (!m_pending && decision_in == 3'd1);
         n_checks++; if (pc_out !== m_pc) $display("FAIL rnd_pc[%0d]: got %h exp %h", i, pc_out, m_pc); else n_pass++;
         n_checks++; if (npc_out !== m_pc + 32'd4) $display("FAIL rnd_npc[%0d]: got %h exp %h", i, npc_out, m_pc + 32'd4); else n_pass++;
         n_checks++; if (if_id_flush !== exp_if) $display("FAIL rnd_if_id[%0d]: got %b exp %b", i, if_id_flush, exp_if); else n_pass++;
         n_checks++; if (id_ex_flush !== exp_id) $display("FAIL rnd_id_ex[%0d]: got %b exp %b", i, id_ex_flush, exp_id); else n_pass++;
         n_checks++; if (imem_req !== !reset) $display("FAIL rnd_imem_req[%0d]: got %b exp %b", i, imem_req, !reset); else n_pass++;
         n_checks++; if (redirect_pending !== (m_pending && !reset)) $display("FAIL rnd_pending[%0d]: got %b exp %b", i, redirect_pending, m_pending && !reset); else n_pass++;
         n_checks++; if (redirect_count !== 16'(m_count)) $display("FAIL rnd_count[%0d]: got %0d exp %0d", i, redirect_count, m_count); else n_pass++;
         n_checks++; if (decode_err !== m_err) $display("FAIL rnd_err[%0d]: got %b exp %b", i, decode_err, m_err); else n_pass++;
         model_update();
         tick();
      end
      reset = 1'b0;
   endtask

   task automatic test_saturation;
      do_reset();
      set_in(3'd2, 32'h0, 32'h40, 32'h0, 1'b0, 1'b1);
      repeat (65534) tick();
      n_checks++; if (redirect_count !== 16'hFFFE) $display("FAIL sat_pre: got %h exp fffe", redirect_count); else n_pass++;
      tick();
      n_checks++; if (redirect_count !== 16'hFFFF) $display("FAIL sat_reach: got %h exp ffff", redirect_count); else n_pass++;
      tick();
      n_checks++; if (redirect_count !== 16'hFFFF) $display("FAIL sat_hold: got %h exp ffff", redirect_count); else n_pass++;
      n_checks++; if (pc_out !== 32'h40) $display("FAIL sat_pc: got %h exp 00000040", pc_out); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      set_in(3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      test_reset();
      test_sequential();
      test_branch_stall();
      test_jalr_pend();
      test_wrap();
      test_decode_err();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 decision_in  input  3  redirect select from branch/jump decision logic: 000 seq, 001 branch, 010 JAL, 011 JALR, 100-111 reserved.
REQ-005 branch_target  input  32  branch target address from EX stage.
REQ-006 jal_target  input  32  JAL target address from ID stage.
REQ-007 jalr_target  input  32  JALR target address (rs1+imm).
REQ-008 stall  input  1  load-use hazard hold request; freezes PC.
REQ-009 imem_ready  input  1  instruction memory accepts fetch at current PC this cycle.
REQ-010 pc_out  output  32  registered current fetch PC.
REQ-011 npc_out  output  32  pc_out + 4, combinational.
REQ-012 imem_req  output  1  fetch request valid.
REQ-013 if_id_flush  output  1  flush IF/ID register this cycle.
REQ-014 id_ex_flush  output  1  flush ID/EX register this cycle.
REQ-015 redirect_pending  output  1  high while a latched redirect awaits imem_ready.
REQ-016 redirect_count  output  16  saturating count of accepted redirects.
REQ-017 decode_err  output  1  sticky flag: reserved decision_in code seen.

Function
REQ-018 States SHALL be RUN and PEND; reset enters RUN.
REQ-019 Redirect target SHALL be: 001 branch_target, 010 jal_target, 011 jalr_target; targets SHALL have bit 0 forced to 0.
REQ-020 Reserved codes 100-111 SHALL be treated as 000 and SHALL set decode_err until reset.
REQ-021 RUN, redirect code, imem_ready=1: pc_out <= target at next edge; stay RUN.
REQ-022 RUN, redirect code, imem_ready=0: latch target into pending register, go PEND; pc_out unchanged.
REQ-023 RUN, no redirect, stall=1 or imem_ready=0: pc_out holds.
REQ-024 RUN, no redirect, stall=0, imem_ready=1: pc_out <= pc_out + 4, wrapping modulo 2^32.
REQ-025 PEND, imem_ready=1: pc_out <= pending target, go RUN, regardless of stall.
REQ-026 PEND: decision_in SHALL be ignored (no retarget, no count, decode_err still updated).
REQ-027 Redirect SHALL take priority over stall in RUN (wrong-path stall discarded).
REQ-028 Flush outputs combinational in decision cycle: 001 -> if_id_flush=1, id_ex_flush=1; 010/011 -> if_id_flush=1, id_ex_flush=0; PEND -> if_id_flush=1 every cycle; else both 0.
REQ-029 imem_req SHALL be 1 in all non-reset cycles, 0 while reset=1.
REQ-030 redirect_count SHALL increment by 1 per accepted redirect (REQ-021/022 entry), saturate at 16'hFFFF.
REQ-031 Redirect latency: target visible on pc_out exactly one cycle after acceptance when imem_ready=1.

Reset
REQ-032 While reset=1 at an edge: pc_out <= RESET_PC, state RUN, pending register 0, redirect_count 0, decode_err 0.
REQ-033 During reset cycles if_id_flush=1, id_ex_flush=1, imem_req=0, redirect_pending=0.
REQ-034 Reset asserted in PEND SHALL discard the pending target.

Verification
REQ-035 Reset, then 3 cycles decision=000, stall=0, ready=1 -> pc_out 0,4,8,12; flushes 0.
REQ-036 pc_out=0x100, decision=001, branch_target=0x200, stall=1 -> next pc_out=0x200; if_id/id_ex_flush=1,1 that cycle; redirect_count=1.
REQ-037 decision=011, jalr_target=0x305, ready=0 for 2 cycles then 1 -> redirect_pending 1 for 2 cycles, if_id_flush=1, pc_out=0x304 after ready; decision=001 during PEND ignored.
REQ-038 pc_out=0xFFFF_FFFC, seq advance -> pc_out=0x0000_0000.
REQ-039 decision=101 -> sequential advance, decode_err=1 sticky until reset; reset in PEND -> pc_out=RESET_PC, pending cleared.
REQ-040 Force redirect_count=16'hFFFE, two redirects -> count holds 16'hFFFF.
